// File: rtl/io_ccff_load_ctrl_if.sv
// Bitstream handshake and configuration-chain signals of the IO ccff load controller.
// master = bitstream source / chain side, slave = the load controller.
interface io_ccff_load_ctrl_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] bs_data;
    logic              bs_valid;
    logic              bs_ready;
    logic              ccff_head;
    logic              config_enable;
    logic              ccff_tail;
    logic              rb_bit;
    logic              rb_valid;

    modport master (
        output bs_data,
        output bs_valid,
        output ccff_tail,
        input  bs_ready,
        input  ccff_head,
        input  config_enable,
        input  rb_bit,
        input  rb_valid
    );

    modport slave (
        input  bs_data,
        input  bs_valid,
        input  ccff_tail,
        output bs_ready,
        output ccff_head,
        output config_enable,
        output rb_bit,
        output rb_valid
    );
endinterface

// File: rtl/io_ccff_load_ctrl.sv
// Loads the IO-tile configuration chain from a word-wide bitstream, LSB first,
// keeping the pads isolated until the whole chain has been shifted.
module io_ccff_load_ctrl #(
    parameter int CHAIN_LEN = 22,
    parameter int WORD_W    = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    io_ccff_load_ctrl_if.slave bus,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W   = $clog2(CHAIN_LEN + 1);
    localparam int REM_W   = $clog2(WORD_W + 1);
    localparam int CMP_W   = (CNT_W > REM_W) ? CNT_W : REM_W;
    localparam int STALL_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0]   CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CMP_W-1:0]   WORD_W_C    = CMP_W'(WORD_W);
    localparam logic [STALL_W-1:0] STALL_LAST  = STALL_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [STALL_W-1:0] STALL_MAX   = '1;
    localparam logic               TIMEOUT_EN  = (TIMEOUT != 0);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [WORD_W-1:0]  sreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic [REM_W-1:0]   rem_cnt;

    logic [CMP_W-1:0]   bits_left;
    logic [CMP_W-1:0]   nshift;
    logic               start_ok;
    logic               accept;
    logic               stall_hit;
    logic               last_bit;
    logic               chain_full;

    logic               ccff_head_q;
    logic               config_enable_q;
    logic               rb_bit_q;
    logic               rb_valid_q;
    logic               isol_n_q;
    logic               done_q;
    logic               err_q;

    // bit_cnt counts bits already presented on ccff_head, so it is complete on the last SHIFT cycle.
    always_comb begin
        bits_left  = CMP_W'(CHAIN_LEN_C - bit_cnt);
        nshift     = (bits_left < WORD_W_C) ? bits_left : WORD_W_C;
        start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
        accept     = (state == ST_LOAD) && bus.bs_valid;
        stall_hit  = TIMEOUT_EN && (state == ST_LOAD) && !bus.bs_valid && (stall_cnt == STALL_LAST);
        last_bit   = (state == ST_SHIFT) && (rem_cnt == '0);
        chain_full = (bit_cnt == CHAIN_LEN_C);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    state_nxt = ST_SHIFT;
                end else if (stall_hit) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    state_nxt = chain_full ? ST_DONE : ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The first bit of a word goes out on the accepting edge, so rem_cnt holds the bits still to come.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            sreg      <= '0;
            bit_cnt   <= '0;
            stall_cnt <= '0;
            rem_cnt   <= '0;
        end else if (start_ok) begin
            bit_cnt   <= '0;
            stall_cnt <= '0;
            rem_cnt   <= '0;
        end else if (accept) begin
            sreg      <= bus.bs_data >> 1;
            rem_cnt   <= REM_W'(nshift - CMP_W'(1));
            bit_cnt   <= bit_cnt + 1'b1;
            stall_cnt <= '0;
        end else if (state == ST_LOAD) begin
            if (stall_cnt != STALL_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end else if ((state == ST_SHIFT) && !last_bit) begin
            sreg    <= sreg >> 1;
            rem_cnt <= rem_cnt - 1'b1;
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            ccff_head_q     <= 1'b0;
            config_enable_q <= 1'b0;
        end else if (accept) begin
            ccff_head_q     <= bus.bs_data[0];
            config_enable_q <= 1'b1;
        end else if ((state == ST_SHIFT) && !last_bit) begin
            ccff_head_q     <= sreg[0];
            config_enable_q <= 1'b1;
        end else begin
            ccff_head_q     <= 1'b0;
            config_enable_q <= 1'b0;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            rb_bit_q   <= 1'b0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= config_enable_q;
            if (config_enable_q) begin
                rb_bit_q <= bus.ccff_tail;
            end
        end
    end

    // Pads are released only once the final chain bit has been shifted in.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            isol_n_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (start_ok) begin
            isol_n_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (last_bit && chain_full) begin
            isol_n_q <= 1'b1;
            done_q   <= 1'b1;
        end else if (stall_hit) begin
            err_q    <= 1'b1;
        end
    end

    assign bus.bs_ready      = (state == ST_LOAD);
    assign bus.ccff_head     = ccff_head_q;
    assign bus.config_enable = config_enable_q;
    assign bus.rb_bit        = rb_bit_q;
    assign bus.rb_valid      = rb_valid_q;
    assign IO_ISOL_N         = isol_n_q;
    assign busy              = (state == ST_LOAD) || (state == ST_SHIFT);
    assign done              = done_q;
    assign err               = err_q;

endmodule

// File: tb/tb_io_ccff_load_ctrl.sv
// Scoreboard bench for io_ccff_load_ctrl: expected head/readback bits are queued as words
// are accepted and popped whenever the controller shifts or returns a readback bit.
module tb_io_ccff_load_ctrl;

    localparam int CHAIN_LEN = 22;
    localparam int WORD_W    = 8;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic              pReset;
    logic              start_drv;
    logic              sel;
    logic [WORD_W-1:0] bs_data;
    logic              bs_valid;
    logic              start_main;
    logic              start_to;
    logic              isol_main, busy_main, done_main, err_main;
    logic              isol_to, busy_to, done_to, err_to;

    logic [CHAIN_LEN-1:0] chain       = '0;
    logic                 preload_req = 1'b0;
    logic [CHAIN_LEN-1:0] preload_val = '0;

    io_ccff_load_ctrl_if #(.WORD_W(WORD_W)) bus ();
    io_ccff_load_ctrl_if #(.WORD_W(WORD_W)) bus_to ();

    assign start_main       = start_drv & ~sel;
    assign start_to         = start_drv & sel;
    assign bus.bs_data      = bs_data;
    assign bus.bs_valid     = bs_valid;
    assign bus.ccff_tail    = chain[0];
    assign bus_to.bs_data   = bs_data;
    assign bus_to.bs_valid  = bs_valid;
    assign bus_to.ccff_tail = 1'b0;

    io_ccff_load_ctrl #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .TIMEOUT(1024)) dut (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .start     (start_main),
        .bus       (bus.slave),
        .IO_ISOL_N (isol_main),
        .busy      (busy_main),
        .done      (done_main),
        .err       (err_main)
    );

    io_ccff_load_ctrl #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .TIMEOUT(16)) dut_to (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .start     (start_to),
        .bus       (bus_to.slave),
        .IO_ISOL_N (isol_to),
        .busy      (busy_to),
        .done      (done_to),
        .err       (err_to)
    );

    logic cur_enable, cur_head, cur_ready, cur_done, cur_err, cur_isol, cur_busy, cur_rb_valid, cur_rb_bit;
    assign cur_enable   = sel ? bus_to.config_enable : bus.config_enable;
    assign cur_head     = sel ? bus_to.ccff_head     : bus.ccff_head;
    assign cur_ready    = sel ? bus_to.bs_ready      : bus.bs_ready;
    assign cur_rb_valid = sel ? bus_to.rb_valid      : bus.rb_valid;
    assign cur_rb_bit   = sel ? bus_to.rb_bit        : bus.rb_bit;
    assign cur_done     = sel ? done_to : done_main;
    assign cur_err      = sel ? err_to  : err_main;
    assign cur_isol     = sel ? isol_to : isol_main;
    assign cur_busy     = sel ? busy_to : busy_main;

    // External chain model: shifts toward the tail whenever the controller enables it.
    always @(posedge prog_clk) begin
        if (preload_req) begin
            chain <= preload_val;
        end else if (bus.config_enable) begin
            chain <= {bus.ccff_head, chain[CHAIN_LEN-1:1]};
        end
    end

    int cyc = 0;
    always @(posedge prog_clk) cyc <= cyc + 1;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    bit exp_head[$];
    bit exp_rb[$];
    int enable_count = 0;
    int rb_count     = 0;
    bit mon_on       = 1'b0;
    bit rb_check_on  = 1'b0;

    always @(negedge prog_clk) begin
        if (mon_on) begin
            if (cur_enable) begin
                enable_count++;
                if (exp_head.size() == 0) begin
                    check_output("head_unexpected_enable", 32'(cur_enable), 32'd0);
                end else begin
                    check_output("ccff_head", 32'(cur_head), 32'(exp_head.pop_front()));
                end
            end else begin
                check_output("head_idle", 32'(cur_head), 32'd0);
            end
            if (cur_rb_valid) begin
                rb_count++;
                if (rb_check_on) begin
                    if (exp_rb.size() == 0) begin
                        check_output("rb_unexpected_valid", 32'(cur_rb_valid), 32'd0);
                    end else begin
                        check_output("rb_bit", 32'(cur_rb_bit), 32'(exp_rb.pop_front()));
                    end
                end
            end
        end
    end

    int start_cyc = 0;
    int en_base   = 0;
    int rb_base   = 0;
    int sent_bits = 0;

    task automatic apply_start();
        start_drv = 1'b1;
        @(negedge prog_clk);
        start_drv = 1'b0;
        start_cyc = cyc;
        en_base   = enable_count;
        rb_base   = rb_count;
        sent_bits = 0;
        exp_head.delete();
        check_output("start_busy", 32'(cur_busy), 32'd1);
        check_output("start_done", 32'(cur_done), 32'd0);
        check_output("start_err", 32'(cur_err), 32'd0);
        check_output("start_isol", 32'(cur_isol), 32'd0);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!cur_ready && k < 100) begin
            @(negedge prog_clk);
            k++;
        end
        if (!cur_ready) check_output("ready_timeout", 32'(cur_ready), 32'd1);
    endtask

    task automatic apply_stimulus(input logic [WORD_W-1:0] w, input int stall);
        int nb;
        if (stall > 0) begin
            bs_valid = 1'b0;
            wait_ready();
            for (int i = 0; i < stall; i++) begin
                check_output("stall_ready", 32'(cur_ready), 32'd1);
                check_output("stall_enable", 32'(cur_enable), 32'd0);
                @(negedge prog_clk);
            end
        end
        bs_data  = w;
        bs_valid = 1'b1;
        wait_ready();
        @(posedge prog_clk);
        nb = (CHAIN_LEN - sent_bits < WORD_W) ? CHAIN_LEN - sent_bits : WORD_W;
        for (int i = 0; i < nb; i++) exp_head.push_back(w[i]);
        sent_bits += nb;
        @(negedge prog_clk);
    endtask

    task automatic finish_load(input string tag, input int exp_cycle);
        int k = 0;
        while (!cur_done && !cur_err && k < 300) begin
            @(negedge prog_clk);
            k++;
        end
        check_output({tag, "_done_cycle"}, 32'(cyc - start_cyc + 1), 32'(exp_cycle));
        check_output({tag, "_done"}, 32'(cur_done), 32'd1);
        check_output({tag, "_err"}, 32'(cur_err), 32'd0);
        check_output({tag, "_isol"}, 32'(cur_isol), 32'd1);
        check_output({tag, "_busy"}, 32'(cur_busy), 32'd0);
        check_output({tag, "_ready"}, 32'(cur_ready), 32'd0);
        check_output({tag, "_enable_in_done"}, 32'(cur_enable), 32'd0);
        check_output({tag, "_enable_count"}, 32'(enable_count - en_base), 32'(CHAIN_LEN));
        check_output({tag, "_bits_left"}, 32'(exp_head.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_head"}, 32'(bus.ccff_head), 32'd0);
        check_output({tag, "_enable"}, 32'(bus.config_enable), 32'd0);
        check_output({tag, "_rb_bit"}, 32'(bus.rb_bit), 32'd0);
        check_output({tag, "_rb_valid"}, 32'(bus.rb_valid), 32'd0);
        check_output({tag, "_ready"}, 32'(bus.bs_ready), 32'd0);
        check_output({tag, "_isol"}, 32'(isol_main), 32'd0);
        check_output({tag, "_busy"}, 32'(busy_main), 32'd0);
        check_output({tag, "_done"}, 32'(done_main), 32'd0);
        check_output({tag, "_err"}, 32'(err_main), 32'd0);
    endtask

    task automatic load_default_words(input string tag);
        apply_stimulus(8'hA5, 0);
        apply_stimulus(8'h3C, 0);
        apply_stimulus(8'hFF, 0);
        bs_valid = 1'b0;
        finish_load(tag, 26);
    endtask

    initial begin
        pReset    = 1'b1;
        start_drv = 1'b0;
        sel       = 1'b0;
        bs_data   = '0;
        bs_valid  = 1'b0;
        repeat (3) @(negedge prog_clk);
        check_all_zero("reset");
        check_output("reset_to_err", 32'(err_to), 32'd0);
        pReset = 1'b0;
        mon_on = 1'b1;
        @(negedge prog_clk);

        $display("[TB] scenario 1: basic load");
        apply_start();
        load_default_words("s1");

        $display("[TB] scenario 2: readback");
        preload_val = 22'h2AAAAA;
        preload_req = 1'b1;
        @(negedge prog_clk);
        preload_req = 1'b0;
        exp_rb.delete();
        for (int i = 0; i < CHAIN_LEN; i++) exp_rb.push_back(preload_val[i]);
        rb_check_on = 1'b1;
        apply_start();
        apply_stimulus(8'h00, 0);
        apply_stimulus(8'h00, 0);
        apply_stimulus(8'h00, 0);
        bs_valid = 1'b0;
        finish_load("s2", 26);
        @(negedge prog_clk);
        check_output("s2_rb_count", 32'(rb_count - rb_base), 32'(CHAIN_LEN));
        check_output("s2_rb_left", 32'(exp_rb.size()), 32'd0);
        check_output("s2_chain", 32'(chain), 32'd0);
        rb_check_on = 1'b0;

        $display("[TB] scenario 3: stall before second word");
        apply_start();
        apply_stimulus(8'hA5, 0);
        apply_stimulus(8'h3C, 50);
        apply_stimulus(8'hFF, 0);
        bs_valid = 1'b0;
        finish_load("s3", 76);

        $display("[TB] scenario 4: timeout");
        sel = 1'b1;
        @(negedge prog_clk);
        apply_start();
        bs_valid = 1'b0;
        for (int k = 0; k < 100 && !cur_err; k++) @(negedge prog_clk);
        check_output("s4_err_cycle", 32'(cyc - start_cyc), 32'd16);
        check_output("s4_err", 32'(cur_err), 32'd1);
        check_output("s4_isol", 32'(cur_isol), 32'd0);
        check_output("s4_busy", 32'(cur_busy), 32'd0);
        check_output("s4_ready", 32'(cur_ready), 32'd0);
        check_output("s4_enable_count", 32'(enable_count - en_base), 32'd0);
        repeat (3) @(negedge prog_clk);
        check_output("s4_err_held", 32'(cur_err), 32'd1);
        apply_start();
        load_default_words("s4");
        sel = 1'b0;
        @(negedge prog_clk);

        $display("[TB] scenario 5: reset mid-shift");
        apply_start();
        apply_stimulus(8'hA5, 0);
        apply_stimulus(8'h3C, 0);
        @(negedge prog_clk);
        mon_on = 1'b0;
        pReset = 1'b1;
        @(negedge prog_clk);
        check_all_zero("s5_reset");
        pReset   = 1'b0;
        bs_valid = 1'b0;
        exp_head.delete();
        mon_on = 1'b1;
        @(negedge prog_clk);
        check_output("s5_idle_busy", 32'(busy_main), 32'd0);
        apply_start();
        load_default_words("s5");

        $display("[TB] scenario 6: start during shift and in done");
        apply_start();
        apply_stimulus(8'hA5, 0);
        start_drv = 1'b1;
        @(negedge prog_clk);
        start_drv = 1'b0;
        check_output("s6_shift_busy", 32'(cur_busy), 32'd1);
        apply_stimulus(8'h3C, 0);
        apply_stimulus(8'hFF, 0);
        bs_valid = 1'b0;
        finish_load("s6a", 26);
        apply_start();
        load_default_words("s6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
